mt9v034_capture: RTL and testbench

Pixel-stream receiver for the MT9V034 sensor; the inbound counterpart of the clock, reset and trigger outputs the FPGA drives to the camera. The block samples the camera's FRAME_VALID, LINE_VALID and DOUT[9:0] in the 24 MHz camera clock domain (the clock forwarded to the sensor's SYSCLK). It captures exactly one frame per `arm` request and emits addressed 8-bit pixel writes for a downstream frame buffer, with completion and error flags.

---
 rtl/mt9v034_capture_if.sv | 35 +++
 rtl/mt9v034_capture.sv | 181 ++++++++++++++++++
 tb/tb_mt9v034_capture.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mt9v034_capture_if.sv
// ---------------------------------------------------------------------------
// mt9v034_capture_if
//   Pixel write bus from the MT9V034 capture block to a frame buffer.
//
//   pix_we is a write strobe with no ready/back-pressure: every cycle that
//   pix_we is high, pix_data must be stored at pix_addr in that same cycle.
//
//   Signals
//     pix_data  [7:0]         pixel value (upper 8 bits of sensor DOUT)
//     pix_addr  [ADDR_W-1:0]  linear address y*H_ACTIVE + x
//     pix_we                  one-cycle write strobe per accepted pixel
//
//   Modports
//     master  capture block (drives the bus)
//     slave   frame buffer (receives the bus)
// ---------------------------------------------------------------------------
interface mt9v034_capture_if #(
    parameter int ADDR_W = 19
);
    logic [7:0]        pix_data;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_we;

    modport master (
        output pix_data,
        output pix_addr,
        output pix_we
    );

    modport slave (
        input pix_data,
        input pix_addr,
        input pix_we
    );
endinterface

// File: rtl/mt9v034_capture.sv
// ---------------------------------------------------------------------------
// mt9v034_capture
//   Single-frame pixel receiver for the MT9V034 parallel output. Runs in the
//   camera clock domain (the clock forwarded to the sensor SYSCLK). One `arm`
//   request captures exactly one complete frame; the pixels come out as
//   addressed 8-bit writes on the pix bus.
//
//   Ports
//     clk          camera-domain clock
//     reset        synchronous, active-high
//     arm          single-cycle capture request (ignored while busy)
//     frame_valid  sensor FRAME_VALID
//     line_valid   sensor LINE_VALID
//     dout[9:0]    sensor pixel data
//     pix          pixel write bus (master): pix_data, pix_addr, pix_we
//     busy         high from accepted arm until frame_done
//     frame_done   one-cycle pulse at the end of the captured frame
//     frame_err    sticky geometry error for the last captured frame
//     line_count   lines received in the current capture (saturates)
//     state_dbg    current FSM state, for observation only
// ---------------------------------------------------------------------------
module mt9v034_capture #(
    parameter int H_ACTIVE = 752,
    parameter int V_ACTIVE = 480,
    parameter int ADDR_W   = 19
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  frame_valid,
    input  logic                  line_valid,
    input  logic [9:0]            dout,
    mt9v034_capture_if.master     pix,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_err,
    output logic [9:0]            line_count,
    output logic [2:0]            state_dbg
);

    // x never exceeds H_ACTIVE; y saturates at V_ACTIVE+1 so "y != V_ACTIVE"
    // stays truthful however many extra lines the sensor sends.
    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 2);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_GAP = 3'd1,
        S_WAIT_SOF = 3'd2,
        S_CAPTURE  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t            state;
    logic              fv_r, lv_r, fv_q, lv_q;
    logic [9:0]        d_r;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] addr;

    logic          fv_rise, fv_fall, line_end, pix_ok;
    logic [YW-1:0] y_inc, y_next;
    logic          unused_low_bits;

    assign state_dbg = state;

    // The two LSBs of DOUT are not stored in the 8-bit frame buffer.
    assign unused_low_bits = ^d_r[1:0];

    assign fv_rise = fv_r & ~fv_q;
    assign fv_fall = ~fv_r & fv_q;

    // A line ends on a LINE_VALID fall inside the frame, or when the frame
    // closes while LINE_VALID is still high (the line is truncated by FV).
    assign line_end = (lv_q & ~lv_r & (fv_r | fv_q)) | (fv_fall & lv_r);

    assign pix_ok = (x < XW'(H_ACTIVE)) && (y < YW'(V_ACTIVE));
    assign y_inc  = (y == YW'(V_ACTIVE + 1)) ? y : y + YW'(1);
    assign y_next = line_end ? y_inc : y;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            fv_r         <= 1'b0;
            lv_r         <= 1'b0;
            fv_q         <= 1'b0;
            lv_q         <= 1'b0;
            d_r          <= '0;
            x            <= '0;
            y            <= '0;
            addr         <= '0;
            pix.pix_data <= '0;
            pix.pix_addr <= '0;
            pix.pix_we   <= 1'b0;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            line_count   <= '0;
        end else begin
            fv_r <= frame_valid;
            lv_r <= line_valid;
            d_r  <= dout;
            fv_q <= fv_r;
            lv_q <= lv_r;

            pix.pix_we <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                // DONE also accepts arm so a request in the done cycle is
                // not lost while busy is already low.
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    if (arm) begin
                        state      <= S_WAIT_GAP;
                        busy       <= 1'b1;
                        frame_err  <= 1'b0;
                        line_count <= '0;
                    end
                end

                // Skip any frame already in progress.
                S_WAIT_GAP: begin
                    if (!fv_r) state <= S_WAIT_SOF;
                end

                S_WAIT_SOF: begin
                    if (fv_rise) begin
                        state <= S_CAPTURE;
                        y     <= '0;
                        // LINE_VALID may rise together with FRAME_VALID;
                        // that first pixel belongs to this frame.
                        if (lv_r) begin
                            pix.pix_we   <= 1'b1;
                            pix.pix_data <= d_r[9:2];
                            pix.pix_addr <= '0;
                            x            <= XW'(1);
                            addr         <= ADDR_W'(1);
                        end else begin
                            x    <= '0;
                            addr <= '0;
                        end
                    end
                end

                S_CAPTURE: begin
                    if (fv_r && lv_r) begin
                        if (pix_ok) begin
                            pix.pix_we   <= 1'b1;
                            pix.pix_data <= d_r[9:2];
                            pix.pix_addr <= addr;
                            x            <= x + XW'(1);
                            addr         <= addr + ADDR_W'(1);
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end

                    // Exclusive with the pixel branch: a line end needs
                    // lv_r or fv_r low.
                    if (line_end) begin
                        if (x != XW'(H_ACTIVE)) frame_err <= 1'b1;
                        x <= '0;
                        y <= y_inc;
                        if (line_count != 10'd1023) line_count <= line_count + 10'd1;
                    end

                    if (fv_fall) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                        if (y_next != YW'(V_ACTIVE)) frame_err <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mt9v034_capture.sv
// ---------------------------------------------------------------------------
// tb_mt9v034_capture
//   Bench for mt9v034_capture with a small 4x3 geometry. A frame-level model
//   in the driver predicts the pixel writes and the end-of-frame status; one
//   compare process checks the DUT against it every cycle.
// ---------------------------------------------------------------------------
module tb_mt9v034_capture;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int AW = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       arm, frame_valid, line_valid;
  logic [9:0] dout;
  logic       busy, frame_done, frame_err;
  logic [9:0] line_count;
  logic [2:0] state_dbg;

  mt9v034_capture_if #(.ADDR_W(AW)) pix();

  mt9v034_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .arm(arm),
    .frame_valid(frame_valid),
    .line_valid(line_valid),
    .dout(dout),
    .pix(pix),
    .busy(busy),
    .frame_done(frame_done),
    .frame_err(frame_err),
    .line_count(line_count),
    .state_dbg(state_dbg)
  );

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  logic [AW+7:0] exp_q[$];       // {addr, data} per expected write
  logic [10:0]   done_q[$];      // {frame_err, line_count} per expected done
  int            done_cyc_q[$];  // cycle at which frame_done must be seen

  int            wr_count = 0;
  logic [AW+7:0] wr_log[$];
  bit            run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // frame-level model state
  bit m_busy = 1'b0;   // an arm has been accepted and its frame not yet done
  bit m_gap_ok = 1'b0; // FV has been low since the arm
  bit m_cap = 1'b0;    // the frame currently on the pins is being captured
  bit m_err = 1'b0;
  int m_y = 0;
  bit m_last_err = 1'b0;
  int m_last_lc = 0;

  always @(negedge clk) begin
    if (run_cmp) begin
      if (pix.pix_we) begin
        wr_count++;
        wr_log.push_back({pix.pix_addr, pix.pix_data});
        if (exp_q.size() == 0) begin
          check("pix_we_unexpected", 32'(pix.pix_we), 32'd0);
        end else begin
          logic [AW+7:0] e;
          e = exp_q.pop_front();
          check("pix_addr", 32'(pix.pix_addr), 32'(e[AW+7:8]));
          check("pix_data", 32'(pix.pix_data), 32'(e[7:0]));
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) begin
          check("frame_done_unexpected", 32'(frame_done), 32'd0);
        end else begin
          logic [10:0] d;
          int c;
          d = done_q.pop_front();
          c = done_cyc_q.pop_front();
          check("frame_err_at_done", 32'(frame_err), 32'(d[10]));
          check("line_count_at_done", 32'(line_count), 32'(d[9:0]));
          check("frame_done_cycle", 32'(cyc), 32'(c));
          check("busy_low_at_done", 32'(busy), 32'd0);
          check("writes_before_done", 32'(exp_q.size()), 32'd0);
        end
      end
    end
  end

  // driver tasks
  task automatic tick(input logic fv, input logic lv, input logic [9:0] d);
    @(negedge clk);
    if (arm) begin
      arm = 1'b0;
      check("busy_after_arm", 32'(busy), 32'(m_busy));
    end
    frame_valid = fv;
    line_valid  = lv;
    dout        = d;
  endtask

  task automatic model_arm();
    if (!m_busy) begin
      m_busy   = 1'b1;
      m_gap_ok = !frame_valid;
    end
  endtask

  task automatic do_arm();
    if (!m_busy) begin
      check("frame_err_held", 32'(frame_err), 32'(m_last_err));
      check("line_count_held", 32'(line_count), 32'(m_last_lc));
    end
    @(negedge clk);
    arm = 1'b1;
    model_arm();
  endtask

  task automatic end_line(input int len);
    if (m_cap) begin
      if (len != H) m_err = 1'b1;
      m_y++;
    end
  endtask

  task automatic end_frame(input int fall_cyc);
    if (m_cap) begin
      if (m_y != V) m_err = 1'b1;
      done_q.push_back({m_err, 10'(m_y > 1023 ? 1023 : m_y)});
      done_cyc_q.push_back(fall_cyc + 2);
      m_last_err = m_err;
      m_last_lc  = (m_y > 1023) ? 1023 : m_y;
      m_busy = 1'b0;
      m_cap  = 1'b0;
    end else if (m_busy) begin
      m_gap_ok = 1'b1;
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_pix_we", 32'(pix.pix_we), 32'd0);
    check("rst_pix_addr", 32'(pix.pix_addr), 32'd0);
    check("rst_pix_data", 32'(pix.pix_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_line_count", 32'(line_count), 32'd0);
  endtask

  // frame description used by drive_frame
  int frame_lens[$];
  int arm_line  = -1;  // arm on the first pixel of this line
  bit fv_cut    = 1'b0; // FV falls while LV is still high on the last line
  int rst_after = -1;  // assert reset after this many pixels
  bit use_ramp  = 1'b0; // dout = 4*k instead of random

  task automatic drive_frame();
    int k;
    bit aborted;
    logic [9:0] d;
    k = 0;
    aborted = 1'b0;
    repeat (3) tick(1'b0, 1'b0, 10'($urandom_range(0, 1023)));
    tick(1'b1, 1'b0, 10'd0);
    m_cap = m_busy && m_gap_ok;
    m_err = 1'b0;
    m_y   = 0;
    tick(1'b1, 1'b0, 10'd0);
    for (int i = 0; i < frame_lens.size(); i++) begin
      for (int j = 0; j < frame_lens[i]; j++) begin
        d = use_ramp ? 10'(4 * k) : 10'($urandom_range(0, 1023));
        tick(1'b1, 1'b1, d);
        if (i == arm_line && j == 0) begin
          arm = 1'b1;
          model_arm();
        end
        if (m_cap) begin
          if (j < H && i < V) exp_q.push_back({AW'(i * H + j), d[9:2]});
          else m_err = 1'b1;
        end
        k++;
        if (k == rst_after) begin
          aborted = 1'b1;
          break;
        end
      end
      if (aborted) break;
      if (fv_cut && i == frame_lens.size() - 1) begin
        tick(1'b0, 1'b1, 10'($urandom_range(0, 1023)));
        end_line(frame_lens[i]);
        end_frame(cyc);
      end else begin
        tick(1'b1, 1'b0, 10'd0);
        end_line(frame_lens[i]);
        tick(1'b1, 1'b0, 10'd0);
      end
    end
    if (aborted) begin
      repeat (3) tick(1'b1, 1'b0, 10'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      check("rst_writes_drained", 32'(exp_q.size()), 32'd0);
      reset      = 1'b0;
      m_busy     = 1'b0;
      m_cap      = 1'b0;
      m_gap_ok   = 1'b0;
      m_last_err = 1'b0;
      m_last_lc  = 0;
      tick(1'b0, 1'b0, 10'd0);
    end else if (!fv_cut) begin
      tick(1'b0, 1'b0, 10'd0);
      end_frame(cyc);
    end
    repeat (4) tick(1'b0, 1'b0, 10'd0);
  endtask

  task automatic set_frame(input int nlines, input int len);
    frame_lens.delete();
    for (int i = 0; i < nlines; i++) frame_lens.push_back(len);
    arm_line  = -1;
    fv_cut    = 1'b0;
    rst_after = -1;
    use_ramp  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    arm = 1'b0;
    frame_valid = 1'b0;
    line_valid = 1'b0;
    dout = 10'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    run_cmp = 1'b1;
    repeat (2) tick(1'b0, 1'b0, 10'd0);

    // nominal frame, ramp data
    set_frame(3, 4);
    use_ramp = 1'b1;
    wr_count = 0;
    wr_log.delete();
    do_arm();
    drive_frame();
    check("nominal_writes", 32'(wr_count), 32'd12);
    if (wr_log.size() == 12) begin
      check("nominal_last_addr", 32'(wr_log[11][AW+7:8]), 32'd11);
      check("nominal_data5", 32'(wr_log[5][7:0]), 32'd5);
    end
    check("nominal_err", 32'(frame_err), 32'd0);
    check("nominal_lines", 32'(line_count), 32'd3);

    // arm mid-frame: that frame is skipped, the next one is captured
    set_frame(3, 4);
    arm_line = 1;
    wr_count = 0;
    drive_frame();
    check("midarm_skipped", 32'(wr_count), 32'd0);
    set_frame(3, 4);
    drive_frame();
    check("midarm_next_writes", 32'(wr_count), 32'd12);

    // long second line
    set_frame(3, 4);
    frame_lens[1] = 6;
    wr_count = 0;
    do_arm();
    drive_frame();
    check("long_writes", 32'(wr_count), 32'd12);
    check("long_err", 32'(frame_err), 32'd1);

    // short frame
    set_frame(2, 4);
    wr_count = 0;
    do_arm();
    drive_frame();
    check("short_writes", 32'(wr_count), 32'd8);
    check("short_err", 32'(frame_err), 32'd1);
    check("short_lines", 32'(line_count), 32'd2);

    // FV falls while LV is still high: last line still counts
    set_frame(3, 4);
    fv_cut = 1'b1;
    do_arm();
    drive_frame();
    check("fvcut_err", 32'(frame_err), 32'd0);
    check("fvcut_lines", 32'(line_count), 32'd3);

    // reset after 5 pixels, then a frame without arm
    set_frame(3, 4);
    rst_after = 5;
    wr_count = 0;
    do_arm();
    drive_frame();
    check("reset_writes", 32'(wr_count), 32'd5);
    set_frame(3, 4);
    wr_count = 0;
    drive_frame();
    check("after_reset_no_writes", 32'(wr_count), 32'd0);

    // re-arm while busy, then an unarmed frame
    set_frame(3, 4);
    arm_line = 1;
    wr_count = 0;
    do_arm();
    drive_frame();
    check("rearm_writes", 32'(wr_count), 32'd12);
    set_frame(3, 4);
    wr_count = 0;
    drive_frame();
    check("rearm_next_ignored", 32'(wr_count), 32'd0);

    // randomized frames
    for (int n = 0; n < 12; n++) begin
      int r;
      frame_lens.delete();
      for (int i = 0; i < $urandom_range(2, 4); i++)
        frame_lens.push_back(($urandom_range(0, 9) < 6) ? H : $urandom_range(3, 5));
      arm_line  = -1;
      rst_after = -1;
      use_ramp  = 1'b0;
      fv_cut    = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 2);
      if (r == 1) do_arm();
      else if (r == 2) arm_line = 0;
      drive_frame();
    end

    repeat (5) tick(1'b0, 1'b0, 10'd0);
    check("final_writes_pending", 32'(exp_q.size()), 32'd0);
    check("final_done_pending", 32'(done_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
